// File: rtl/w0rm_bus_pkg.sv
// Shared types and helpers for the W0RM peripheral bus fabric.
// Flattened-vector helpers cover up to 16 fields of up to 64 bits each.
package w0rm_bus_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } bus_state_t;

  localparam int unsigned MAX_PORTS   = 16;
  localparam int unsigned MAX_FIELD_W = 64;
  localparam int unsigned FLAT_W      = MAX_PORTS * MAX_FIELD_W;

  localparam logic [MAX_FIELD_W-1:0] ERR_DATA = '0;

  // Field idx of a flattened vector of width-bit fields, zero-extended to MAX_FIELD_W.
  function automatic logic [MAX_FIELD_W-1:0] field_of(
    input logic [FLAT_W-1:0] flat,
    input int unsigned       idx,
    input int unsigned       width
  );
    logic [FLAT_W-1:0]      shifted;
    logic [MAX_FIELD_W-1:0] mask;
    shifted = flat >> (idx * width);
    mask    = (width >= MAX_FIELD_W) ? '1
                                     : ((MAX_FIELD_W'(1) << width) - MAX_FIELD_W'(1));
    return shifted[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/w0rm_bus_addr_decoder.sv
// Combinational base/mask address decoder; one-hot select with lowest-index
// priority when several windows overlap.
module w0rm_bus_addr_decoder
  import w0rm_bus_pkg::*;
#(
  parameter int unsigned                     NUM_PORTS  = 4,
  parameter int unsigned                     ADDR_WIDTH = 32,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR_MASKS = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]  sel,
  output logic                  hit
);

  logic [NUM_PORTS-1:0]  match;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    match = '0;
    base  = '0;
    mask  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      base     = ADDR_WIDTH'(field_of(FLAT_W'(BASE_ADDRS), i, ADDR_WIDTH));
      mask     = ADDR_WIDTH'(field_of(FLAT_W'(ADDR_MASKS), i, ADDR_WIDTH));
      match[i] = ((addr & mask) == (base & mask));
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (match[i] && (sel == '0)) sel[i] = 1'b1;
    end
  end

  assign hit = |match;

endmodule

// File: rtl/w0rm_peripheral_bus_fabric.sv
// N-port address-decoding data-bus fabric with a single outstanding transaction.
// Define W0RM_BUS_FABRIC_TIMEOUT_EN to compile in the unresponsive-slave timeout.
module w0rm_peripheral_bus_fabric
  import w0rm_bus_pkg::*;
#(
  parameter int unsigned                     NUM_PORTS  = 4,
  parameter int unsigned                     DATA_WIDTH = 32,
  parameter int unsigned                     ADDR_WIDTH = 32,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR_MASKS = '0,
  parameter int unsigned                     TIMEOUT    = 16
) (
  input  logic                            bus_clock,
  input  logic                            reset,
  input  logic                            mem_valid_i,
  input  logic                            mem_read_i,
  input  logic                            mem_write_i,
  input  logic [ADDR_WIDTH-1:0]           mem_addr_i,
  input  logic [DATA_WIDTH-1:0]           mem_data_i,
  output logic                            mem_valid_o,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            mem_error_o,
  output logic                            mem_busy_o,
  output logic [NUM_PORTS-1:0]            port_valid_o,
  output logic                            port_read_o,
  output logic                            port_write_o,
  output logic [ADDR_WIDTH-1:0]           port_addr_o,
  output logic [DATA_WIDTH-1:0]           port_data_o,
  input  logic [NUM_PORTS-1:0]            port_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("TIMEOUT must be at least 2");
  end

  bus_state_t            state, state_next;
  logic [NUM_PORTS-1:0]  dec_sel;
  logic                  dec_hit;
  logic [IDX_W-1:0]      sel_idx, sel_q;
  logic                  op_read_q, op_write_q;
  logic                  req, resp_hit, timed_out;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  resp_valid_d, resp_error_d;
  logic [DATA_WIDTH-1:0] resp_data_d;

  w0rm_bus_addr_decoder #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS)
  ) u_decoder (
    .addr(mem_addr_i),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  assign req = mem_valid_i && (mem_read_i || mem_write_i);

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (dec_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign resp_hit = (state == WAIT) && port_valid_i[sel_q];
  assign sel_data = DATA_WIDTH'(field_of(FLAT_W'(port_data_i), 32'(sel_q), DATA_WIDTH));

`ifdef W0RM_BUS_FABRIC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (state == WAIT) && !resp_hit && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Cleared throughout IDLE so it reads 0 on the first WAIT cycle.
  always_ff @(posedge bus_clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!resp_hit && !timed_out) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge bus_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req && dec_hit) state_next = WAIT;
      WAIT:    if (resp_hit || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    port_valid_o = '0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_data_d  = DATA_WIDTH'(ERR_DATA);
    case (state)
      IDLE: begin
        if (req && !reset) begin
          if (dec_hit) begin
            port_valid_o = dec_sel;
          end else begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (resp_hit) begin
          resp_valid_d = 1'b1;
          resp_data_d  = sel_data;
        end else if (timed_out) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_busy_o   = (state == WAIT);
  // Slaves see the accepted operation for the whole transaction, not the stalled core's.
  assign port_read_o  = (state == WAIT) ? op_read_q  : mem_read_i;
  assign port_write_o = (state == WAIT) ? op_write_q : mem_write_i;
  assign port_addr_o  = mem_addr_i;
  assign port_data_o  = mem_data_i;

  always_ff @(posedge bus_clock) begin
    if (reset) begin
      sel_q      <= '0;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
    end else if ((state == IDLE) && req && dec_hit) begin
      sel_q      <= sel_idx;
      op_read_q  <= mem_read_i;
      op_write_q <= mem_write_i;
    end
  end

  always_ff @(posedge bus_clock) begin
    if (reset) begin
      mem_valid_o <= 1'b0;
      mem_error_o <= 1'b0;
      mem_data_o  <= '0;
    end else begin
      mem_valid_o <= resp_valid_d;
      mem_error_o <= resp_error_d;
      mem_data_o  <= resp_data_d;
    end
  end

endmodule

// File: doc/w0rm_peripheral_bus_fabric.md
# w0rm_peripheral_bus_fabric

N-port, address-decoding data-bus fabric between the W0RM core memory port and its slaves (core RAM, GPIO, future peripherals). It is the parametrised successor to the fixed two-port peripheral bus extender. It decodes each request to exactly one slave, tracks the single outstanding transaction, and returns only that slave's response. Unmapped accesses and, optionally, unresponsive slaves complete with an error instead of hanging the core.

## Interface
Parameters:
- NUM_PORTS, 4, number of slave ports (1..16)
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- BASE_ADDRS, {NUM_PORTS{32'h0}}, flattened per-port base address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ADDR_MASKS, {NUM_PORTS{32'h0}}, flattened per-port mask; hit when (addr & mask) == (base & mask)
- TIMEOUT, 16, wait cycles before error response (>=2)

Ports:
- bus_clock  in  1  fabric clock
- reset  in  1  synchronous, active-high reset
- mem_valid_i  in  1  core request strobe
- mem_read_i  in  1  read request
- mem_write_i  in  1  write request
- mem_addr_i  in  ADDR_WIDTH  request address
- mem_data_i  in  DATA_WIDTH  write data
- mem_valid_o  out  1  response strobe to core, one cycle
- mem_data_o  out  DATA_WIDTH  read data; 0 on error
- mem_error_o  out  1  qualifies mem_valid_o: decode miss or timeout
- mem_busy_o  out  1  transaction outstanding; requests ignored
- port_valid_o  out  NUM_PORTS  one-hot request strobe per slave
- port_read_o, port_write_o  out  1 each  broadcast read/write
- port_addr_o  out  ADDR_WIDTH  broadcast address
- port_data_o  out  DATA_WIDTH  broadcast write data
- port_valid_i  in  NUM_PORTS  per-slave response strobe
- port_data_i  in  NUM_PORTS*DATA_WIDTH  per-slave read data, flattened

## Operation
- FSM states: IDLE, WAIT.
- IDLE + mem_valid_i + (read|write):
  - Decoder hit: port_valid_o[sel] asserted combinationally the same cycle. Selected index and current operation are latched. Next state WAIT; counter cleared.
  - Multiple hits: lowest index wins.
  - No hit: no port strobed. Error response registered (mem_valid_o=1, mem_error_o=1, mem_data_o=0) next cycle. State stays IDLE.
- mem_valid_i with neither read nor write: ignored.
- WAIT:
  - Only port_valid_i[sel] is honoured. port_data_i[sel] is registered to mem_data_o; mem_valid_o=1, mem_error_o=0 next cycle. Next state IDLE.
  - Responses from unselected ports are ignored in every state.
  - Response arriving in IDLE (stale or late) is ignored.
- mem_busy_o = (state == WAIT). Requests during WAIT are dropped; the core must hold off.
- Write acknowledgement: the slave response strobe completes writes too. mem_data_o carries slave data unchanged.
- Reset asserted:
  - Next state IDLE; any outstanding transaction is abandoned with no response.
  - mem_valid_o, mem_error_o, mem_busy_o, mem_data_o = 0; counter = 0.
  - port_valid_o forced 0 while reset is high.

## Timing
- Request accepted cycle T; slave responds cycle T+k (k>=1); mem_valid_o at T+k+1.
- Back-to-back: new request may be accepted in the same cycle mem_valid_o is high (state already IDLE).
- Decode miss: error at T+1.
- Timeout counter: 0 at T+1, increments each WAIT cycle without a response.
  - If count == TIMEOUT-1 and no response: error at T+TIMEOUT+1, state IDLE.
  - Response at T+TIMEOUT beats the timeout.
  - Later responses are ignored.
- Counter width: $clog2(TIMEOUT); no wrap possible.

## Configuration
- W0RM_BUS_FABRIC_TIMEOUT_EN defined: timeout counter and timeout error path compiled in, as above.
- Undefined: no counter; WAIT persists until the selected slave responds or reset. mem_error_o is raised only on decode miss.

## Structure
- Package w0rm_bus_pkg:
  - FSM state typedef.
  - Default data on error (all zeros).
  - Helper function extracting field i of a flattened vector.
- Sub-module w0rm_bus_addr_decoder: combinational, parametrised identically; outputs one-hot select (lowest-index priority) and hit flag.
- The fabric holds the FSM, counter and response registers.

## Test plan
- Port0 base 0x00000000 mask 0xFFFFF000; port1 base 0x80000080 mask 0xFFFFFFF0.
  - Stimulus: read 0x00000010; port0 answers 0xDEADBEEF at T+1.
  - Response: mem_valid_o at T+2, data 0xDEADBEEF, error 0.
- Write 0x80000084, data 0xA5.
  - port_valid_o=0b0010 at T; port1 acks at T+3.
  - mem_valid_o at T+4; mem_busy_o high T+1..T+3.
- Read 0x40000000 (unmapped):
  - port_valid_o stays 0; mem_valid_o=1, mem_error_o=1, data 0 at T+1.
- TIMEOUT=16, port0 silent:
  - Error at T+17. A port0 response at T+20 produces no mem_valid_o.
  - Separately, a response at exactly T+16 is returned without error at T+17.
- Port2 asserts port_valid_i with 0x12345678 while port0 is selected; port0 answers 0x1 later.
  - Only 0x1 is returned.
- Reset asserted at T+2 of an outstanding read; port0 answers at T+3.
  - No mem_valid_o; all outputs 0.
  - Request at T+4 after reset release is accepted normally.
